// File: rtl/branch_unit_if.sv
// Branch request/resolution bus between the issue stage (master) and the branch unit (slave).
interface branch_unit_if;
    logic        br_req_i;
    logic [3:0]  br_cond_i;
    logic [15:0] br_target_i;
    logic [15:0] pc_i;
    logic        br_ready_o;
    logic        br_done_o;
    logic        br_taken_o;
    logic [15:0] pc_next_o;

    modport master (
        output br_req_i, br_cond_i, br_target_i, pc_i,
        input  br_ready_o, br_done_o, br_taken_o, pc_next_o
    );

    modport slave (
        input  br_req_i, br_cond_i, br_target_i, pc_i,
        output br_ready_o, br_done_o, br_taken_o, pc_next_o
    );
endinterface

// File: rtl/branch_unit.sv
// Resolves one conditional branch at a time from the ALU flags, producing the next fetch
// address and a pipeline flush pulse of FLUSH_CYCLES cycles for taken branches.
module branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    branch_unit_if.slave br,
    input  logic         flags_pend_i,
    input  logic         zf_i,
    input  logic         sf_i,
    input  logic         cf_i,
    input  logic         of_i,
    output logic         flush_o
);

    typedef enum logic [1:0] {StIdle, StWaitFlags, StResolve, StFlush} state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cond_q, cond_d;
    logic [15:0] target_q, target_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        taken_q, taken_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        cond_true;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_q)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = zf_i;
            4'd2:    cond_true = !zf_i;
            4'd3:    cond_true = sf_i != of_i;
            4'd4:    cond_true = sf_i == of_i;
            4'd5:    cond_true = zf_i || (sf_i != of_i);
            4'd6:    cond_true = !zf_i && (sf_i == of_i);
            4'd7:    cond_true = cf_i;
            4'd8:    cond_true = !cf_i;
            4'd9:    cond_true = cf_i || zf_i;
            4'd10:   cond_true = !cf_i && !zf_i;
            default: cond_true = 1'b0; // 11 is "never"; 12..15 reserved, resolve as not taken
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        target_d  = target_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        taken_d   = taken_q;
        pc_next_d = pc_next_q;

        unique case (state_q)
            StIdle: begin
                if (br.br_req_i) begin
                    cond_d   = br.br_cond_i;
                    target_d = br.br_target_i;
                    pc_d     = br.pc_i;
                    state_d  = flags_pend_i ? StWaitFlags : StResolve;
                end
            end
            StWaitFlags: state_d = StResolve;
            StResolve: begin
                done_d    = 1'b1;
                taken_d   = cond_true;
                pc_next_d = cond_true ? target_q : pc_q + 16'd1;
                if (cond_true) begin
                    state_d = StFlush;
                    cnt_d   = FlushLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cond_q    <= 4'd0;
            target_q  <= 16'd0;
            pc_q      <= 16'd0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            pc_next_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            target_q  <= target_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign br.br_ready_o = (state_q == StIdle);
    assign br.br_done_o  = done_q;
    assign br.br_taken_o = taken_q;
    assign br.pc_next_o  = pc_next_q;
    assign flush_o       = (state_q == StFlush);

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: one instance with a 1-cycle flush and one with a 3-cycle flush.
module tb_branch_unit;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flags_pend_i, zf_i, sf_i, cf_i, of_i;
    logic flush1, flush3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    branch_unit_if bus1 ();
    branch_unit_if bus3 ();

    branch_unit #(.FLUSH_CYCLES(1)) dut1 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .br           (bus1.slave),
        .flags_pend_i (flags_pend_i),
        .zf_i         (zf_i),
        .sf_i         (sf_i),
        .cf_i         (cf_i),
        .of_i         (of_i),
        .flush_o      (flush1)
    );

    branch_unit #(.FLUSH_CYCLES(3)) dut3 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .br           (bus3.slave),
        .flags_pend_i (flags_pend_i),
        .zf_i         (zf_i),
        .sf_i         (sf_i),
        .cf_i         (cf_i),
        .of_i         (of_i),
        .flush_o      (flush3)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic r1, input logic r3, input logic [3:0] c,
                          input logic [15:0] p, input logic [15:0] t);
        bus1.br_req_i    = r1;
        bus3.br_req_i    = r3;
        bus1.br_cond_i   = c;
        bus3.br_cond_i   = c;
        bus1.pc_i        = p;
        bus3.pc_i        = p;
        bus1.br_target_i = t;
        bus3.br_target_i = t;
    endtask

    // flags packed as {zf, sf, cf, of}
    task automatic run_br(input string tag, input logic [3:0] c, input logic [3:0] f,
                          input logic [15:0] p, input logic [15:0] t, input logic exp_t);
        {zf_i, sf_i, cf_i, of_i} = f;
        flags_pend_i = 1'b0;
        set_br(1'b1, 1'b0, c, p, t);
        tick();
        bus1.br_req_i = 1'b0;
        tick();
        chk({tag, "_done"}, 16'(bus1.br_done_o), 16'd1);
        chk({tag, "_taken"}, 16'(bus1.br_taken_o), 16'(exp_t));
        chk({tag, "_pcnext"}, bus1.pc_next_o, exp_t ? t : p + 16'd1);
        chk({tag, "_flush"}, 16'(flush1), 16'(exp_t));
        tick();
        chk({tag, "_ready_after"}, 16'(bus1.br_ready_o), 16'd1);
        chk({tag, "_flush_after"}, 16'(flush1), 16'd0);
    endtask

    logic [3:0] tc_cond  [13] = '{4'd2, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                  4'd10, 4'd11, 4'd12, 4'd15};
    logic [3:0] tc_flags [13] = '{4'b0000, 4'b1000, 4'b0100, 4'b0100, 4'b0101, 4'b0010,
                                  4'b0010, 4'b1000, 4'b0000, 4'b0010, 4'b1111, 4'b1111,
                                  4'b0000};
    logic       tc_taken [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        // Reset held for two edges while a request is presented
        rst_i = 1'b0;
        flags_pend_i = 1'b0;
        {zf_i, sf_i, cf_i, of_i} = 4'b0000;
        set_br(1'b1, 1'b1, 4'd0, 16'h0010, 16'h0040);
        tick();
        tick();
        chk("rst_ready1", 16'(bus1.br_ready_o), 16'd1);
        chk("rst_done1", 16'(bus1.br_done_o), 16'd0);
        chk("rst_taken1", 16'(bus1.br_taken_o), 16'd0);
        chk("rst_pcnext1", bus1.pc_next_o, 16'h0000);
        chk("rst_flush1", 16'(flush1), 16'd0);
        chk("rst_ready3", 16'(bus3.br_ready_o), 16'd1);
        chk("rst_flush3", 16'(flush3), 16'd0);
        rst_i = 1'b1;
        set_br(1'b0, 1'b0, 4'd0, 16'h0010, 16'h0040);
        tick();
        tick();
        chk("rst_noaccept_done", 16'(bus1.br_done_o), 16'd0);
        chk("rst_noaccept_ready", 16'(bus1.br_ready_o), 16'd1);

        // JMP, no pending flags: done at N+2, ready at N+3
        set_br(1'b1, 1'b0, 4'd0, 16'h0010, 16'h0040);
        tick();
        bus1.br_req_i = 1'b0;
        chk("jmp_n1_ready", 16'(bus1.br_ready_o), 16'd0);
        chk("jmp_n1_done", 16'(bus1.br_done_o), 16'd0);
        tick();
        chk("jmp_done", 16'(bus1.br_done_o), 16'd1);
        chk("jmp_taken", 16'(bus1.br_taken_o), 16'd1);
        chk("jmp_pcnext", bus1.pc_next_o, 16'h0040);
        chk("jmp_flush", 16'(flush1), 16'd1);
        tick();
        chk("jmp_n3_ready", 16'(bus1.br_ready_o), 16'd1);
        chk("jmp_n3_flush", 16'(flush1), 16'd0);
        chk("jmp_n3_done", 16'(bus1.br_done_o), 16'd0);
        chk("jmp_hold_pcnext", bus1.pc_next_o, 16'h0040);

        // Pending flags: zf becomes 1 only after the accept cycle
        flags_pend_i = 1'b1;
        zf_i = 1'b0;
        set_br(1'b1, 1'b0, 4'd1, 16'h0050, 16'h0100);
        tick();
        bus1.br_req_i = 1'b0;
        flags_pend_i = 1'b0;
        zf_i = 1'b1;
        chk("pend_n1_ready", 16'(bus1.br_ready_o), 16'd0);
        tick();
        chk("pend_n2_done", 16'(bus1.br_done_o), 16'd0);
        tick();
        chk("pend_done", 16'(bus1.br_done_o), 16'd1);
        chk("pend_taken", 16'(bus1.br_taken_o), 16'd1);
        chk("pend_pcnext", bus1.pc_next_o, 16'h0100);
        chk("pend_flush", 16'(flush1), 16'd1);
        tick();
        chk("pend_ready", 16'(bus1.br_ready_o), 16'd1);

        // Not taken with PC wrap
        {zf_i, sf_i, cf_i, of_i} = 4'b0101;
        set_br(1'b1, 1'b0, 4'd3, 16'hFFFF, 16'h4444);
        tick();
        bus1.br_req_i = 1'b0;
        chk("wrap_n1_flush", 16'(flush1), 16'd0);
        tick();
        chk("wrap_done", 16'(bus1.br_done_o), 16'd1);
        chk("wrap_taken", 16'(bus1.br_taken_o), 16'd0);
        chk("wrap_pcnext", bus1.pc_next_o, 16'h0000);
        chk("wrap_flush", 16'(flush1), 16'd0);
        chk("wrap_ready", 16'(bus1.br_ready_o), 16'd1);
        tick();
        chk("wrap_n3_flush", 16'(flush1), 16'd0);
        chk("wrap_n3_done", 16'(bus1.br_done_o), 16'd0);

        // Condition table including reserved codes
        for (int i = 0; i < 13; i++) begin
            run_br($sformatf("cond%0d_%0d", tc_cond[i], i), tc_cond[i], tc_flags[i],
                   16'h1000 + 16'(i), 16'h2000 + 16'(i), tc_taken[i]);
        end

        // FLUSH_CYCLES=3, with requests pulsed during flush
        {zf_i, sf_i, cf_i, of_i} = 4'b0000;
        set_br(1'b0, 1'b1, 4'd0, 16'h0020, 16'h0080);
        tick();
        bus3.br_req_i = 1'b0;
        tick();
        chk("f3_done", 16'(bus3.br_done_o), 16'd1);
        chk("f3_pcnext", bus3.pc_next_o, 16'h0080);
        chk("f3_flush1", 16'(flush3), 16'd1);
        set_br(1'b0, 1'b1, 4'd0, 16'h0030, 16'h1234);
        tick();
        bus3.br_req_i = 1'b0;
        chk("f3_flush2", 16'(flush3), 16'd1);
        chk("f3_ready2", 16'(bus3.br_ready_o), 16'd0);
        chk("f3_done2", 16'(bus3.br_done_o), 16'd0);
        bus3.br_req_i = 1'b1;
        tick();
        bus3.br_req_i = 1'b0;
        chk("f3_flush3", 16'(flush3), 16'd1);
        tick();
        chk("f3_flush_end", 16'(flush3), 16'd0);
        chk("f3_ready_end", 16'(bus3.br_ready_o), 16'd1);
        tick();
        tick();
        chk("f3_ignored_done", 16'(bus3.br_done_o), 16'd0);
        chk("f3_ignored_pcnext", bus3.pc_next_o, 16'h0080);
        chk("f3_ignored_ready", 16'(bus3.br_ready_o), 16'd1);

        // Reset in the second flush cycle
        set_br(1'b0, 1'b1, 4'd0, 16'h0060, 16'h0090);
        tick();
        bus3.br_req_i = 1'b0;
        tick();
        chk("rf_flush1", 16'(flush3), 16'd1);
        tick();
        chk("rf_flush2", 16'(flush3), 16'd1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("rf_flush_cleared", 16'(flush3), 16'd0);
        chk("rf_ready", 16'(bus3.br_ready_o), 16'd1);
        chk("rf_done", 16'(bus3.br_done_o), 16'd0);
        chk("rf_pcnext_clr", bus3.pc_next_o, 16'h0000);
        tick();
        chk("rf_no_done", 16'(bus3.br_done_o), 16'd0);
        chk("rf_flush_stays", 16'(flush3), 16'd0);

        // Reset while waiting on pending flags aborts without a done pulse
        flags_pend_i = 1'b1;
        set_br(1'b1, 1'b0, 4'd0, 16'h0070, 16'h00A0);
        tick();
        bus1.br_req_i = 1'b0;
        flags_pend_i = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("rw_ready", 16'(bus1.br_ready_o), 16'd1);
        tick();
        chk("rw_no_done1", 16'(bus1.br_done_o), 16'd0);
        tick();
        chk("rw_no_done2", 16'(bus1.br_done_o), 16'd0);
        chk("rw_no_flush", 16'(flush1), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
